// File: rtl/parser_pkg.sv
// parser_pkg: shared dispatch state encodings, queue-tag defaults and the round-robin ready-scan picker.
package parser_pkg;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} dispatch_state_e;
  localparam int C_QTAG_LSB_DEFAULT = 141;
  localparam int MAX_QUEUES = 16;
  function automatic int qidx_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  // First ready queue at or after ptr, wrapping modulo n (n need not be a power of two).
  function automatic logic [3:0] rr_pick(input logic [MAX_QUEUES-1:0] rdy, input logic [3:0] ptr, input int n);
    logic [4:0] idx;
    logic found;
    rr_pick = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_QUEUES; i++) begin
      idx = 5'(ptr) + 5'(i);
      if (idx >= 5'(n)) idx = idx - 5'(n);
      if (i < n && !found && rdy[idx[3:0]]) begin
        rr_pick = idx[3:0];
        found = 1'b1;
      end
    end
  endfunction
endpackage

// File: rtl/pkt_queue_dispatcher_if.sv
// pkt_queue_dispatcher_if: packet input stream, per-queue output streams, PHV in/out and statistics bundle.
// slave modport is the dispatcher side; master modport is the parser/queue side driving it.
interface pkt_queue_dispatcher_if #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_QUEUES         = 4,
  parameter int PKT_HDR_LEN          = 1024
);
  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep;
  logic                             s_axis_tlast;
  logic                             s_axis_tvalid;
  logic                             s_axis_tready;
  logic [C_S_AXIS_DATA_WIDTH-1:0]   m_axis_tdata;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]  m_axis_tuser;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep;
  logic                             m_axis_tlast;
  logic [C_NUM_QUEUES-1:0]          m_axis_tvalid;
  logic [C_NUM_QUEUES-1:0]          m_axis_tready;
  logic                             phv_in_valid;
  logic [PKT_HDR_LEN-1:0]           phv_in;
  logic                             phv_out_valid;
  logic [PKT_HDR_LEN-1:0]           phv_out;
  logic                             phv_tag_err;
  logic [C_NUM_QUEUES*32-1:0]       stat_pkt_cnt;
  modport slave (
    input  s_axis_tdata, s_axis_tuser, s_axis_tkeep, s_axis_tlast, s_axis_tvalid, m_axis_tready, phv_in_valid, phv_in,
    output s_axis_tready, m_axis_tdata, m_axis_tuser, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
    output phv_out_valid, phv_out, phv_tag_err, stat_pkt_cnt
  );
  modport master (
    output s_axis_tdata, s_axis_tuser, s_axis_tkeep, s_axis_tlast, s_axis_tvalid, m_axis_tready, phv_in_valid, phv_in,
    input  s_axis_tready, m_axis_tdata, m_axis_tuser, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
    input  phv_out_valid, phv_out, phv_tag_err, stat_pkt_cnt
  );
endinterface

// File: rtl/fallthrough_small_fifo.sv
// fallthrough_small_fifo: small first-word-fall-through FIFO; ports clk, reset (sync, active-high), din/wr_en, dout/rd_en, full, empty.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 2,
  parameter int MAX_DEPTH_BITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0]          mem_q [2**MAX_DEPTH_BITS];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [MAX_DEPTH_BITS:0]   cnt_q, cnt_d;
  logic                      wr, rd;
  assign full  = cnt_q[MAX_DEPTH_BITS];
  assign empty = cnt_q == '0;
  assign dout  = mem_q[rd_ptr_q];
  assign wr    = wr_en && !full;
  assign rd    = rd_en && !empty;
  always_comb begin
    wr_ptr_d = wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = (wr && !rd) ? cnt_q + 1'b1 : (rd && !wr) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= din;
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/pkt_queue_dispatcher.sv
// pkt_queue_dispatcher: round-robin packet steering to ready queues with one-hot queue tagging of the matching PHV.
// Ports: axis_clk, areset (sync, active-high), bus (pkt_queue_dispatcher_if.slave: stream in/out, PHV in/out, tag error, stats).
// Build option PKT_DISPATCH_STATS_EN enables per-queue packet counters; otherwise stat_pkt_cnt is tied to zero.
module pkt_queue_dispatcher
  import parser_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH     = 256,
  parameter int C_S_AXIS_TUSER_WIDTH    = 128,
  parameter int C_NUM_QUEUES            = 4,
  parameter int PKT_HDR_LEN             = 1024,
  parameter int C_QTAG_LSB              = C_QTAG_LSB_DEFAULT,
  parameter int C_ORDER_FIFO_DEPTH_BITS = 4
) (
  input logic                  axis_clk,
  input logic                  areset,
  pkt_queue_dispatcher_if.slave bus
);
  localparam int QW = qidx_width(C_NUM_QUEUES);
  dispatch_state_e         state_q, state_d;
  logic [QW-1:0]           sel_q, sel_d, rr_ptr_q, rr_ptr_d, fifo_dout;
  logic                    fifo_full, fifo_empty, start, beat, last_beat;
  logic [C_NUM_QUEUES-1:0] tag;
  logic [PKT_HDR_LEN-1:0]  phv_out_q, phv_out_d;
  logic                    phv_out_valid_q, phv_tag_err_q, phv_tag_err_d;
  assign start     = state_q == IDLE && bus.s_axis_tvalid && !fifo_full && |bus.m_axis_tready;
  assign beat      = state_q == SEND && bus.s_axis_tvalid && bus.m_axis_tready[sel_q];
  assign last_beat = beat && bus.s_axis_tlast;
  assign tag       = fifo_empty ? '0 : {{(C_NUM_QUEUES-1){1'b0}}, 1'b1} << fifo_dout;
  always_comb begin
    state_d       = start ? SEND : last_beat ? IDLE : state_q;
    sel_d         = start ? QW'(rr_pick(16'(bus.m_axis_tready), 4'(rr_ptr_q), C_NUM_QUEUES)) : sel_q;
    rr_ptr_d      = last_beat ? (sel_q == QW'(C_NUM_QUEUES - 1) ? '0 : sel_q + 1'b1) : rr_ptr_q;
    phv_tag_err_d = phv_tag_err_q | (bus.phv_in_valid & fifo_empty);
    phv_out_d     = phv_out_q;
    if (bus.phv_in_valid) begin
      phv_out_d = bus.phv_in;
      phv_out_d[C_QTAG_LSB +: C_NUM_QUEUES] = tag;
    end
  end
  always_ff @(posedge axis_clk) begin
    if (areset) begin
      state_q         <= IDLE;
      sel_q           <= '0;
      rr_ptr_q        <= '0;
      phv_out_q       <= '0;
      phv_out_valid_q <= 1'b0;
      phv_tag_err_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      sel_q           <= sel_d;
      rr_ptr_q        <= rr_ptr_d;
      phv_out_q       <= phv_out_d;
      phv_out_valid_q <= bus.phv_in_valid;
      phv_tag_err_q   <= phv_tag_err_d;
    end
  end
  // Queue index is pushed in the selection cycle so a PHV can never see its packet's entry missing.
  fallthrough_small_fifo #(.WIDTH(QW), .MAX_DEPTH_BITS(C_ORDER_FIFO_DEPTH_BITS)) u_order_fifo (
    .clk   (axis_clk),
    .reset (areset),
    .din   (sel_d),
    .wr_en (start),
    .rd_en (bus.phv_in_valid),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
  assign bus.s_axis_tready = state_q == SEND && bus.m_axis_tready[sel_q];
  assign bus.m_axis_tvalid = (state_q == SEND && bus.s_axis_tvalid) ? {{(C_NUM_QUEUES-1){1'b0}}, 1'b1} << sel_q : '0;
  assign bus.m_axis_tdata  = bus.s_axis_tdata;
  assign bus.m_axis_tuser  = bus.s_axis_tuser;
  assign bus.m_axis_tkeep  = bus.s_axis_tkeep;
  assign bus.m_axis_tlast  = bus.s_axis_tlast;
  assign bus.phv_out       = phv_out_q;
  assign bus.phv_out_valid = phv_out_valid_q;
  assign bus.phv_tag_err   = phv_tag_err_q;
`ifdef PKT_DISPATCH_STATS_EN
  logic [C_NUM_QUEUES*32-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = cnt_q;
    if (last_beat) cnt_d[sel_q*32 +: 32] = cnt_q[sel_q*32 +: 32] + 32'd1;
  end
  always_ff @(posedge axis_clk) begin
    if (areset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign bus.stat_pkt_cnt = cnt_q;
`else
  assign bus.stat_pkt_cnt = '0;
`endif
endmodule

// File: tb/tb_pkt_queue_dispatcher.sv
// tb_pkt_queue_dispatcher: self-checking bench for pkt_queue_dispatcher with packet/PHV scoreboards.
module tb_pkt_queue_dispatcher;
  localparam int N = 4;
  localparam int H = 1024;
  localparam int LSB = 141;
  typedef struct {
    logic [N-1:0] rdy;
    int           nbeats;
    int           exp_q;
  } vec_t;
  logic axis_clk = 1'b0;
  logic areset = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  int exp_pkt[$];
  int ord_model[$];
  logic [H-1:0] exp_phv[$];
  int unsigned cnt_model[N];
  vec_t vecs[12];
  pkt_queue_dispatcher_if bus ();
  pkt_queue_dispatcher dut (.axis_clk(axis_clk), .areset(areset), .bus(bus));
  always #5 axis_clk = ~axis_clk;
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [N*32-1:0] stat_exp();
    logic [N*32-1:0] r;
    r = '0;
`ifdef PKT_DISPATCH_STATS_EN
    for (int q = 0; q < N; q++) r[q*32 +: 32] = cnt_model[q];
`endif
    return r;
  endfunction
  always @(negedge axis_clk) begin
    if (!areset) begin
      if (|bus.m_axis_tvalid) begin
        if (exp_pkt.size() == 0) check("m_valid_unexpected", 128'(bus.m_axis_tvalid), 0);
        else begin
          check("m_valid_queue", 128'(bus.m_axis_tvalid), 128'(4'b0001 << exp_pkt[0]));
          if (bus.m_axis_tlast && |(bus.m_axis_tvalid & bus.m_axis_tready)) void'(exp_pkt.pop_front());
        end
      end
      if (bus.phv_out_valid) begin
        if (exp_phv.size() == 0) check("phv_unexpected", 128'(bus.phv_out_valid), 0);
        else begin
          n_tests++;
          if (bus.phv_out !== exp_phv[0]) begin
            n_fail++;
            $display("FAIL phv_out: got tag %b (%0d bits differ) expected tag %b", bus.phv_out[LSB +: N],
                     $countones(bus.phv_out ^ exp_phv[0]), exp_phv[0][LSB +: N]);
          end
          void'(exp_phv.pop_front());
        end
      end
    end
  end
  task automatic send_pkt(input logic [N-1:0] rdy, input int nbeats, input int exp_q, input bit toggle);
    int b = 0;
    int cyc = 0;
    bit acc;
    exp_pkt.push_back(exp_q);
    ord_model.push_back(exp_q);
    bus.m_axis_tready = rdy;
    while (b < nbeats && cyc < 100) begin
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata = {8{$urandom()}};
      bus.s_axis_tlast = (b == nbeats - 1);
      @(negedge axis_clk);
      acc = bus.s_axis_tready;
      if (acc) begin
        check("tready_gated", 128'(bus.s_axis_tready & ~bus.m_axis_tready[exp_q]), 0);
        check("tdata_bcast", bus.m_axis_tdata[127:0], bus.s_axis_tdata[127:0]);
      end
      @(posedge axis_clk);
      #1;
      cyc++;
      if (acc) begin
        b++;
        if (b == nbeats) cnt_model[exp_q]++;
      end
      if (toggle) bus.m_axis_tready = cyc[0] ? rdy & ~(N'(1) << exp_q) : rdy;
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast = 1'b0;
    if (b < nbeats) check("pkt_timeout", 128'(b), 128'(nbeats));
  endtask
  task automatic send_phv();
    logic [H-1:0] d;
    logic [N-1:0] tag;
    for (int w = 0; w < H / 32; w++) d[w*32 +: 32] = $urandom();
    tag = '0;
    if (ord_model.size() > 0) tag = N'(1) << ord_model.pop_front();
    bus.phv_in = d;
    bus.phv_in_valid = 1'b1;
    d[LSB +: N] = tag;
    exp_phv.push_back(d);
    @(posedge axis_clk);
    #1;
    bus.phv_in_valid = 1'b0;
    @(posedge axis_clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bit acc;
    for (int i = 0; i < 8; i++) vecs[i] = '{4'b1111, 1, i % 4};
    vecs[8]  = '{4'b1111, 1, 0};
    vecs[9]  = '{4'b1111, 2, 1};
    vecs[10] = '{4'b1011, 1, 3};
    vecs[11] = '{4'b1111, 1, 0};
    foreach (cnt_model[q]) cnt_model[q] = 0;
    bus.s_axis_tdata = '0;
    bus.s_axis_tuser = '0;
    bus.s_axis_tkeep = '1;
    bus.s_axis_tlast = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    bus.m_axis_tready = '0;
    bus.phv_in_valid = 1'b0;
    bus.phv_in = '0;
    repeat (3) @(posedge axis_clk);
    #1;
    areset = 1'b0;
    @(negedge axis_clk);
    check("rst_s_tready", 128'(bus.s_axis_tready), 0);
    check("rst_m_tvalid", 128'(bus.m_axis_tvalid), 0);
    check("rst_phv_valid", 128'(bus.phv_out_valid), 0);
    check("rst_phv_zero", 128'(|bus.phv_out), 0);
    check("rst_tag_err", 128'(bus.phv_tag_err), 0);
    check("rst_stats", bus.stat_pkt_cnt, 0);
    @(posedge axis_clk);
    #1;
    foreach (vecs[i]) begin
      send_pkt(vecs[i].rdy, vecs[i].nbeats, vecs[i].exp_q, 1'b0);
      send_phv();
    end
    send_pkt(4'b0010, 3, 1, 1'b1);
    bus.m_axis_tready = '0;
    bus.s_axis_tvalid = 1'b1;
    @(negedge axis_clk);
    check("idle_after_tlast_tready", 128'(bus.s_axis_tready), 0);
    check("idle_after_tlast_valid", 128'(bus.m_axis_tvalid), 0);
    @(posedge axis_clk);
    #1;
    bus.s_axis_tvalid = 1'b0;
    send_phv();
    for (int i = 0; i < 16; i++) send_pkt(4'b1111, 1, (2 + i) % 4, 1'b0);
    exp_pkt.push_back(2);
    ord_model.push_back(2);
    bus.m_axis_tready = 4'b1111;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tlast = 1'b1;
    repeat (4) begin
      @(negedge axis_clk);
      check("fifo_full_blocks", 128'(bus.s_axis_tready), 0);
      @(posedge axis_clk);
      #1;
    end
    send_phv();
    @(negedge axis_clk);
    check("full_release_tready", 128'(bus.s_axis_tready), 1);
    @(posedge axis_clk);
    #1;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast = 1'b0;
    cnt_model[2]++;
    repeat (16) send_phv();
    @(negedge axis_clk);
    check("tag_err_clear", 128'(bus.phv_tag_err), 0);
    check("stats_running", bus.stat_pkt_cnt, stat_exp());
    @(posedge axis_clk);
    #1;
    send_phv();
    repeat (3) begin
      @(negedge axis_clk);
      check("tag_err_sticky", 128'(bus.phv_tag_err), 1);
      @(posedge axis_clk);
      #1;
    end
    exp_pkt.push_back(3);
    ord_model.push_back(3);
    bus.m_axis_tready = 4'b1111;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tlast = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      @(negedge axis_clk);
      acc = bus.s_axis_tready;
      @(posedge axis_clk);
      #1;
    end
    if (!acc) check("midpkt_first_beat", 128'(acc), 1);
    areset = 1'b1;
    @(posedge axis_clk);
    #1;
    areset = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    exp_pkt.delete();
    ord_model.delete();
    exp_phv.delete();
    foreach (cnt_model[q]) cnt_model[q] = 0;
    @(negedge axis_clk);
    check("abort_s_tready", 128'(bus.s_axis_tready), 0);
    check("abort_m_tvalid", 128'(bus.m_axis_tvalid), 0);
    check("abort_phv_valid", 128'(bus.phv_out_valid), 0);
    check("abort_phv_zero", 128'(|bus.phv_out), 0);
    check("abort_tag_err", 128'(bus.phv_tag_err), 0);
    check("abort_stats", bus.stat_pkt_cnt, 0);
    @(posedge axis_clk);
    #1;
    send_pkt(4'b1111, 1, 0, 1'b0);
    @(negedge axis_clk);
    check("stats_after_reset", bus.stat_pkt_cnt, stat_exp());
    @(posedge axis_clk);
    #1;
    send_phv();
    send_phv();
    @(negedge axis_clk);
    check("tag_err_after_flush", 128'(bus.phv_tag_err), 1);
    check("pkt_sb_drained", 128'(exp_pkt.size()), 0);
    check("phv_sb_drained", 128'(exp_phv.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
